rv32im_fetch_sequencer: RTL
===========================

// Module: rv32im_fetch_sequencer
// PURPOSE
//   Fetch controller that owns and sequences the program counter. Picks the next PC from
//   trap, redirect or sequential (+4) sources and drives pc_next_o into the PC register.
//   Runs a single-outstanding req/ack handshake to instruction memory.
//   Holds the fetched instruction for decode under stall, and discards stale responses after a redirect.
// PARAMETERS
//   PC_WIDTH   32             PC / address width (= `API_PC_WIDTH)
//   RESET_PC   32'h0000_0000  fetch address after reset (= `API_RESET_PC)
// PORTS
//   clk            in   1         clock; all state updates on posedge clk
//   reset          in   1         synchronous, active-high reset
//   trap_valid_i   in   1         trap/exception redirect request (highest priority)
//   trap_vec_i     in   PC_WIDTH  trap target address
//   redirect_i     in   1         branch/jump redirect from execute
//   redirect_pc_i  in   PC_WIDTH  branch/jump target
//   stall_i        in   1         decode cannot accept the held instruction
//   imem_req_o     out  1         instruction memory request
//   imem_addr_o    out  PC_WIDTH  request address; stable while imem_req_o=1
//   imem_ack_i     in   1         memory response valid (same cycle or later)
//   imem_rdata_i   in   32        instruction word, valid with imem_ack_i
//   instr_valid_o  out  1         instr_o/instr_pc_o valid for decode
//   instr_o        out  32        fetched instruction
//   instr_pc_o     out  PC_WIDTH  address of instr_o
//   pc_next_o      out  PC_WIDTH  combinational next value of fetch_pc (drives the PC register)
//   misalign_o     out  1         1-cycle pulse: accepted target had addr[1:0]!=0
// BEHAVIOUR
//   - Reset: state=S_IDLE, fetch_pc=RESET_PC. All outputs 0 except imem_addr_o=RESET_PC.
//   - States:
//     - S_IDLE: next cycle -> S_WAIT.
//     - S_WAIT: imem_req_o=1, imem_addr_o=fetch_pc.
//       - On ack: latch rdata into instr_o, instr_pc_o=fetch_pc; fetch_pc+=4; -> S_HOLD.
//     - S_HOLD: instr_valid_o=1; instr_o and instr_pc_o stable.
//       - ~stall_i: consumed; -> S_WAIT (next req the following cycle).
//       - stall_i: stay in S_HOLD; no request issued.
//     - S_DISCARD: imem_req_o=0; wait for the stale ack, drop its data; -> S_WAIT.
//   - Timing:
//     - Latency: req asserted cycle N, ack cycle N+k (k>=0), instr_valid_o cycle N+k+1.
//     - Peak throughput: 1 instruction / 2 cycles.
//   - Redirect priority: reset > trap_valid_i > redirect_i > sequential.
//   - Redirect target T = trap ? trap_vec_i : redirect_pc_i; fetch_pc <= {T[PC_WIDTH-1:2],2'b00}.
//     - If T[1:0]!=0, misalign_o=1 for the next cycle.
//   - Redirect by state (takes effect next cycle):
//     - S_IDLE / S_HOLD: instr_valid_o deasserts, -> S_WAIT with T.
//     - S_WAIT, no ack this cycle: -> S_DISCARD.
//     - S_WAIT, ack same cycle: drop data, -> S_WAIT with T (no discard).
//     - S_DISCARD: update target, stay until the stale ack arrives.
//   - stall_i is ignored outside S_HOLD. A fetch in flight is never cancelled on the bus.
//   - Arithmetic: fetch_pc+4 wraps modulo 2^PC_WIDTH (FFFF_FFFC -> 0000_0000).
//   - pc_next_o = reset ? RESET_PC : value fetch_pc takes at the next edge.
//   - Reset mid-fetch: returns to S_IDLE. Any ack seen in S_IDLE is ignored, and memory must
//     drop its pending request on reset.
// TESTING
//   1. Release reset, ack at k=0 with rdata=0x00000013 -> req addr 0x0, then instr_valid
//      with instr_pc 0x0; next req addr 0x4.
//   2. stall_i=1 for 3 cycles in S_HOLD -> instr_o/instr_pc_o stable, imem_req_o=0;
//      release -> req addr +4.
//   3. redirect_i to 0x100 while S_WAIT with ack delayed 3 cycles -> stale ack dropped,
//      instr_valid stays 0, next req addr 0x100.
//   4. trap_valid_i (vec 0x80) and redirect_i (0x200) same cycle -> next req 0x80; redirect
//      0x102 -> req 0x100, misalign_o pulses.
//   5. fetch_pc 0xFFFF_FFFC acked -> next req addr 0x0000_0000.
//   6. Assert reset in S_DISCARD, then a late ack -> outputs reset values, ack ignored,
//      fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32im_fetch_sequencer.sv
// rv32im_fetch_sequencer
// Owns the fetch program counter and sequences a single-outstanding req/ack
// fetch to instruction memory. The fetched word is held for decode while it
// stalls, and a response that was already in flight when a redirect arrived
// is dropped rather than handed to decode.
//
// Handshake: imem_req_o is high only in S_WAIT, and imem_addr_o stays at
// fetch_pc for as long as it is high. A beat completes on any cycle where
// imem_req_o && imem_ack_i, including the first cycle of the request.
// Decode takes instr_o/instr_pc_o on any cycle with instr_valid_o && !stall_i.
module rv32im_fetch_sequencer #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trap_valid_i,
    input  logic [PC_WIDTH-1:0] trap_vec_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                stall_i,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [31:0]         imem_rdata_i,
    output logic                instr_valid_o,
    output logic [31:0]         instr_o,
    output logic [PC_WIDTH-1:0] instr_pc_o,
    output logic [PC_WIDTH-1:0] pc_next_o,
    output logic                misalign_o,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_n;
    logic [31:0]         instr_q;
    logic [PC_WIDTH-1:0] instr_pc_q;
    logic                misalign_q;

    logic                redir;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] target_aligned;
    logic                load_instr;

    // Trap wins over a branch redirect; the low two bits are forced to zero
    // so fetch always stays word aligned.
    assign redir          = trap_valid_i | redirect_i;
    assign target         = trap_valid_i ? trap_vec_i : redirect_pc_i;
    assign target_aligned = {target[PC_WIDTH-1:2], 2'b00};

    // Next state, next fetch_pc and the capture strobe for the held instruction.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        load_instr = 1'b0;
        unique case (state)
            S_IDLE: begin
                // Any ack seen here belongs to a request killed by reset.
                state_n = S_WAIT;
                if (redir) fetch_pc_n = target_aligned;
            end
            S_WAIT: begin
                if (redir) begin
                    // An in-flight fetch is never cancelled: if its ack has not
                    // come yet it must be absorbed in S_DISCARD.
                    fetch_pc_n = target_aligned;
                    state_n    = imem_ack_i ? S_WAIT : S_DISCARD;
                end else if (imem_ack_i) begin
                    load_instr = 1'b1;
                    fetch_pc_n = fetch_pc + PC_WIDTH'(4);
                    state_n    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    fetch_pc_n = target_aligned;
                    state_n    = S_WAIT;
                end else if (!stall_i) begin
                    state_n = S_WAIT;
                end
            end
            S_DISCARD: begin
                if (redir) fetch_pc_n = target_aligned;
                if (imem_ack_i) state_n = S_WAIT;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, PC, held instruction and misalign flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            misalign_q <= redir && (target[1:0] != 2'b00);
            if (load_instr) begin
                instr_q    <= imem_rdata_i;
                instr_pc_q <= fetch_pc;
            end
        end
    end

    assign imem_req_o    = (state == S_WAIT);
    assign imem_addr_o   = fetch_pc;
    assign instr_valid_o = (state == S_HOLD);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign misalign_o    = misalign_q;
    assign pc_next_o     = reset ? RESET_PC : fetch_pc_n;
    assign dbg_state     = state;

endmodule
